// File: rtl/typewriter_key_player.sv
// Buffered keystroke player: queues 8-bit key codes and replays them onto the
// typewriter contact lines with shift settle, interlock wait, hold and gap timing.

module tkp_contact #(
  parameter int IDX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic       open,
  input  logic [6:0] idx,
  output logic       q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= 1'b0;
    else if (open)  q <= 1'b0;
    else if (press) q <= (idx == 7'(IDX));
  end
endmodule

module typewriter_key_player #(
  parameter int N_KEYS   = 44,
  parameter int DEPTH    = 8,
  parameter int HOLD_MS  = 20,
  parameter int GAP_MS   = 30,
  parameter int SHIFT_MS = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [7:0]               in_code,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ilk,
  output logic [N_KEYS-1:0]        key_cnt,
  output logic                     cr_cnt,
  output logic                     tab_cnt,
  output logic                     space_cnt,
  output logic                     shift_up,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     bad_code
);
  localparam int AW   = $clog2(DEPTH);
  localparam int NC   = N_KEYS + 3;
  localparam int T_HG = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
  localparam int TMAX = (T_HG > SHIFT_MS) ? T_HG : SHIFT_MS;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_ILK, PRESS, GAP} state_t;
  typedef struct packed {
    logic       up;
    logic [6:0] idx;
  } code_t;

  code_t         mem [DEPTH];
  code_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_n;
  logic [6:0]    cur_idx;
  logic [CW-1:0] cnt;
  state_t        state;
  logic          push, pop, head_ok, press_go, press_end, going_idle;
  logic [NC-1:0] con;

  assign head     = mem[rd_ptr];
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (level != '0);
  assign head_ok  = head.idx <= 7'(N_KEYS + 2);
  assign level_n  = level + (AW+1)'(push) - (AW+1)'(pop);
  assign press_go = (state == WAIT_ILK) && !ilk;
  assign press_end = (state == PRESS) && (cnt == '0);
  // FSM lands in IDLE next cycle: either nothing valid was popped, or GAP expires
  assign going_idle = ((state == IDLE) && !(pop && head_ok)) ||
                      ((state == GAP) && (cnt == '0));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_t'(in_code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_n;
      in_ready <= level_n != (AW+1)'(DEPTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_idx  <= '0;
      cnt      <= '0;
      shift_up <= 1'b0;
      busy     <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      bad_code <= 1'b0;
      busy     <= !going_idle || (level_n != '0);
      // loads below override this, so a tick coinciding with a load is dropped
      if (tick && cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        IDLE: if (pop) begin
          cur_idx <= head.idx;
          if (!head_ok) bad_code <= 1'b1;
          else if (head.up != shift_up) begin
            shift_up <= head.up;
            cnt      <= CW'(SHIFT_MS);
            state    <= SHIFT;
          end else state <= WAIT_ILK;
        end
        SHIFT:    if (cnt == '0) state <= WAIT_ILK;
        WAIT_ILK: if (!ilk) begin
          cnt   <= CW'(HOLD_MS);
          state <= PRESS;
        end
        PRESS: if (cnt == '0) begin
          cnt   <= CW'(GAP_MS);
          state <= GAP;
        end
        GAP:     if (cnt == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_con
    tkp_contact #(.IDX(i)) u_con (
      .clk   (clk),
      .rst   (rst),
      .press (press_go),
      .open  (press_end),
      .idx   (cur_idx),
      .q     (con[i])
    );
  end

  assign {space_cnt, tab_cnt, cr_cnt, key_cnt} = con;
endmodule

// File: doc/typewriter_key_player.md
# typewriter_key_player

Parametrised keystroke sequencer that replays a queue of key codes onto the I/O Writer keyboard contact lines (PL1A character, CR, TAB and SPACE contacts) and the shift-basket position. Key timing is taken from the 1 ms `tick` strobe produced by `timer`. It generalises single hard-coded contact pokes in unit tests and FPGA console bring-up to a buffered, interlock-aware, variable-width key player. It sits between a host or scripted source and the `anc_2` typewriter-side contact inputs.

## Interface
Parameters:
- `N_KEYS`, 44: number of character key contacts (1..125).
- `DEPTH`, 8: code FIFO depth, power of two, ≥2.
- `HOLD_MS`, 20: ticks a contact is held closed (≥1).
- `GAP_MS`, 30: ticks of release gap after each key (≥1).
- `SHIFT_MS`, 50: ticks allowed for basket settle after a shift change (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle 1 ms strobe from `timer`.
- `in_code`  in  8  bit7 = shifted, bits6:0 = key index.
- `in_valid`  in  1  code offered.
- `in_ready`  out  1  FIFO not full.
- `ilk`  in  1  Space/CR/TAB interlock; high = typewriter busy.
- `key_cnt`  out  N_KEYS  one-hot character contact closures.
- `cr_cnt`, `tab_cnt`, `space_cnt`  out  1 each  control contact closures.
- `shift_up`  out  1  shift basket position (1 = upper case).
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `bad_code`  out  1  one-cycle pulse when an out-of-range index is dropped.

## Operation
- Index map: 0..N_KEYS-1 = `key_cnt[i]`; N_KEYS = CR; N_KEYS+1 = TAB; N_KEYS+2 = SPACE; anything higher is invalid.
- FIFO: push on `in_valid && in_ready`. Pop only in IDLE. Simultaneous push and pop when full is not possible, because `in_ready` is low. Push and pop in the same cycle leave `level` unchanged.
- FSM states:
  - IDLE: if FIFO is non-empty, pop into `cur`. Invalid index: pulse `bad_code`, stay IDLE. Valid index with `cur[7]` ≠ `shift_up`: go to SHIFT. Otherwise go to WAIT_ILK.
  - SHIFT: on entry, `shift_up` <= `cur[7]` and load counter with SHIFT_MS. Go to WAIT_ILK when the counter reaches 0.
  - WAIT_ILK: hold while `ilk`=1. When `ilk`=0, go to PRESS: assert the selected contact and load counter with HOLD_MS.
  - PRESS: at counter 0, deassert all contacts, load counter with GAP_MS, go to GAP.
  - GAP: at counter 0, go to IDLE.
- Counter decrements only on `tick`. A tick in the same cycle as the load is ignored. Each timed state therefore lasts N full tick intervals, ±1 tick period of phase.
- At most one contact output is high at any time, and only in PRESS.
- `shift_up` holds its value between keys. It changes only on entry to SHIFT.
- `ilk` is sampled only in WAIT_ILK. Changes during PRESS or GAP are ignored.

## Timing
- Reset values: `key_cnt`=0, `cr_cnt`=`tab_cnt`=`space_cnt`=0, `shift_up`=0, `busy`=0, `level`=0, `in_ready`=1, `bad_code`=0. FSM goes to IDLE and the FIFO is emptied.
- Reset asserted mid-PRESS opens every contact immediately (asynchronously). Queued codes are lost.
- All outputs are registered.
- `in_ready` and `level` update the cycle after a push or pop.
- Latency from push into an empty FIFO while IDLE: pop on the next cycle; contact asserted 2 cycles later when no shift change is needed and `ilk`=0.
- `bad_code` pulses in the cycle after the pop of the invalid code.
- `busy` falls the cycle after GAP exits with the FIFO empty.

## Test plan
- Reset and idle: hold `rst` 10 cycles, then release → all outputs 0, `in_ready`=1, `level`=0, `busy`=0.
- Single lowercase key, HOLD_MS=2, GAP_MS=1, code 0x05 → `key_cnt`=1<<5 for 2 ticks (±1 tick), then 0; `shift_up` stays 0; `busy` low after 1 further tick.
- Shift change, SHIFT_MS=3, codes 0x81 then 0x02 → `shift_up` rises, `key_cnt[1]` closes ≥3 ticks later; `shift_up` falls before `key_cnt[2]` closes; no two contacts ever high together.
- Interlock: hold `ilk`=1, push N_KEYS+2 (SPACE) → `space_cnt` stays 0 for 100 ticks; drop `ilk` → `space_cnt` high within 2 cycles.
- FIFO full/overflow, DEPTH=8, `ilk`=1: push 10 codes back-to-back → `level`=8 with `in_ready`=0 after 8 accepted (first popped into `cur`, so 9 consumed total); release `ilk` → keys play in push order.
- Invalid and reset mid-press: push 0x7F → `bad_code` pulses once, no contact closes. Push 0x03 and assert `rst` during PRESS → `key_cnt`=0 in the same cycle, `level`=0.
